// File: rtl/alu_src_arbiter.sv
// alu_src_arbiter
// Shares one integer ALU operand-select stage between two issue requesters
// (0: integer RS, 1: branch/address-gen RS). A round-robin pick each cycle
// captures the winner's select codes and operands into a single output
// register that drains to the ALU under a valid/ready handshake.
module alu_src_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SRCA_W = 2,
  parameter int SRCB_W = 2,
  parameter int OP_W   = 4,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [SRCA_W-1:0] req0_src_a_sel,
  input  logic [SRCB_W-1:0] req0_src_b_sel,
  input  logic [ADDR_W-1:0] req0_pc,
  input  logic [DATA_W-1:0] req0_rs1,
  input  logic [DATA_W-1:0] req0_rs2,
  input  logic [DATA_W-1:0] req0_imm,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic [SRCA_W-1:0] req1_src_a_sel,
  input  logic [SRCB_W-1:0] req1_src_b_sel,
  input  logic [ADDR_W-1:0] req1_pc,
  input  logic [DATA_W-1:0] req1_rs1,
  input  logic [DATA_W-1:0] req1_rs2,
  input  logic [DATA_W-1:0] req1_imm,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SRCA_W-1:0] out_src_a_sel,
  output logic [SRCB_W-1:0] out_src_b_sel,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_rs1,
  output logic [DATA_W-1:0] out_rs2,
  output logic [DATA_W-1:0] out_imm,
  output logic [OP_W-1:0]   out_op,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_src,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
);

  // One issue slot's worth of operand-select state. Select codes are carried
  // verbatim; the downstream muxes own the decode of unused encodings.
  typedef struct packed {
    logic [SRCA_W-1:0] src_a_sel;
    logic [SRCB_W-1:0] src_b_sel;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [DATA_W-1:0] imm;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
  } payload_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  payload_t    req0_pl;
  payload_t    req1_pl;
  payload_t    out_pl_q;
  payload_t    out_pl_d;
  logic        out_valid_q;
  logic        out_valid_d;
  logic        out_src_q;
  logic        out_src_d;
  logic        rr_q;
  logic        rr_d;
  logic [15:0] cnt0_q;
  logic [15:0] cnt0_d;
  logic [15:0] cnt1_q;
  logic [15:0] cnt1_d;

  logic        accept;
  logic [1:0]  grant;
  logic        handshake;
  logic        winner;

  assign req0_pl = '{req0_src_a_sel, req0_src_b_sel, req0_pc, req0_rs1,
                     req0_rs2, req0_imm, req0_op, req0_tag};
  assign req1_pl = '{req1_src_a_sel, req1_src_b_sel, req1_pc, req1_rs1,
                     req1_rs2, req1_imm, req1_op, req1_tag};

  // Round-robin grant and accept: a lone requester always wins, a tie goes
  // to the requester named by rr; nothing is accepted in reset, on flush or
  // while the output register is stalled.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    grant     = 2'b00;
    accept    = reset_n && !flush && (!out_valid_q || out_ready);
    grant[0]  = req_valid[0] && (!req_valid[1] || !rr_q);
    grant[1]  = req_valid[1] && (!req_valid[0] ||  rr_q);
    req_ready = {2{accept}} & grant;
    handshake = |req_ready;
    winner    = req_ready[1];
  end

  // Next state for the output register, the fairness pointer and counters.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pl_d    = out_pl_q;
    out_src_d   = out_src_q;
    rr_d        = rr_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    if (handshake) begin
      out_valid_d = 1'b1;
      out_pl_d    = winner ? req1_pl : req0_pl;
      out_src_d   = winner;
      rr_d        = ~winner;
      if (!winner && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + 16'd1;
      if ( winner && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + 16'd1;
    end else if (flush || out_ready) begin
      // Killed or drained with nothing new to load; payload keeps stale bits.
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear so an in-flight op drops at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_pl_q    <= '0;
      out_src_q   <= 1'b0;
      rr_q        <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values, independent of statement order within the block.
      out_valid_q <= out_valid_d;
      out_pl_q    <= out_pl_d;
      out_src_q   <= out_src_d;
      rr_q        <= rr_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_src_a_sel = out_pl_q.src_a_sel;
  assign out_src_b_sel = out_pl_q.src_b_sel;
  assign out_pc        = out_pl_q.pc;
  assign out_rs1       = out_pl_q.rs1;
  assign out_rs2       = out_pl_q.rs2;
  assign out_imm       = out_pl_q.imm;
  assign out_op        = out_pl_q.op;
  assign out_tag       = out_pl_q.tag;
  assign out_src       = out_src_q;
  assign grant_cnt0    = cnt0_q;
  assign grant_cnt1    = cnt1_q;

endmodule
